// File: rtl/bp_update_queue.sv
// bp_update_queue
// Collects up to two resolved branches per cycle from the execute pipes and
// sends them one per cycle, oldest first, to the predictor's update port.
// Execute is held off through res_ready whenever a worst-case two-entry
// push might not fit.
module bp_update_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res0_valid,
  input  logic                     res0_taken,
  input  logic [PC_W-1:0]          res0_pc,
  input  logic                     res1_valid,
  input  logic                     res1_taken,
  input  logic [PC_W-1:0]          res1_pc,
  output logic                     res_ready,
  output logic                     is_b_ope,
  output logic                     is_branch,
  output logic [PC_W-1:0]          w_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] slot1;
  logic [CW-1:0] count;

  logic       push0;
  logic       push1;
  logic       do_pop;
  logic [1:0] push_cnt;

  // res_ready only looks at the registered count, so a two-entry push always
  // fits even though this edge's pop is not credited.
  assign res_ready = (count <= READY_MAX);
  assign push0     = res_ready & res0_valid;
  assign push1     = res_ready & res1_valid;
  assign do_pop    = (count != '0);
  assign push_cnt  = {1'b0, push0} + {1'b0, push1};

  // res1 lands directly behind res0 when both push, otherwise in the next
  // free slot, so a lone res1 never leaves a hole.
  assign slot1     = push0 ? (wr_ptr + AW'(1)) : wr_ptr;

  assign occupancy = count;

  // Entry storage; stale contents need no reset because the pointers define
  // which slots are live.
  always_ff @(posedge clk) begin
    if (push0) begin
      pc_mem[wr_ptr]    <= res0_pc;
      taken_mem[wr_ptr] <= res0_taken;
    end
    if (push1) begin
      pc_mem[slot1]    <= res1_pc;
      taken_mem[slot1] <= res1_taken;
    end
  end

  // Pointer and count bookkeeping; reset wins over any same-edge push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_cnt) - CW'(do_pop);
    end
  end

  // Predictor update register: strobe for one cycle per entry, otherwise
  // hold the last outcome and PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_b_ope  <= 1'b0;
      is_branch <= 1'b0;
      w_pc      <= '0;
    end else if (do_pop) begin
      is_b_ope  <= 1'b1;
      is_branch <= taken_mem[rd_ptr];
      w_pc      <= pc_mem[rd_ptr];
    end else begin
      is_b_ope  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// tb_bp_update_queue
// Drives directed and randomised branch resolutions into bp_update_queue.
// A reference model records accepted entries in a scoreboard queue and a
// separate monitor pops that queue whenever the predictor strobe fires.
module tb_bp_update_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 14;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
  } entry_t;

  logic            clk;
  logic            rst;
  logic            res0_valid;
  logic            res0_taken;
  logic [PC_W-1:0] res0_pc;
  logic            res1_valid;
  logic            res1_taken;
  logic [PC_W-1:0] res1_pc;
  logic            res_ready;
  logic            is_b_ope;
  logic            is_branch;
  logic [PC_W-1:0] w_pc;
  logic [$clog2(DEPTH):0] occupancy;

  int checks_total  = 0;
  int checks_passed = 0;

  entry_t sb[$];
  int     mcount     = 0;
  bit     exp_strobe = 0;
  bit     rst_edge   = 0;
  bit     last_acc   = 0;
  bit     mon_en     = 0;
  int     strobe_cnt = 0;
  bit     saw_bp     = 0;
  logic            hold_taken = 1'b0;
  logic [PC_W-1:0] hold_pc    = '0;

  bp_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .res0_valid (res0_valid),
    .res0_taken (res0_taken),
    .res0_pc    (res0_pc),
    .res1_valid (res1_valid),
    .res1_taken (res1_taken),
    .res1_pc    (res1_pc),
    .res_ready  (res_ready),
    .is_b_ope   (is_b_ope),
    .is_branch  (is_branch),
    .w_pc       (w_pc),
    .occupancy  (occupancy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: decides acceptance from its own count and queues accepted entries
  always @(posedge clk) begin
    bit rdy;
    int pushes;
    int pops;
    if (rst) begin
      mcount     = 0;
      sb.delete();
      exp_strobe = 0;
      rst_edge   = 1;
      last_acc   = 0;
    end else begin
      rdy    = (mcount <= DEPTH - 2);
      pops   = (mcount > 0) ? 1 : 0;
      pushes = 0;
      if (rdy && res0_valid) begin
        sb.push_back('{taken: res0_taken, pc: res0_pc});
        pushes++;
      end
      if (rdy && res1_valid) begin
        sb.push_back('{taken: res1_taken, pc: res1_pc});
        pushes++;
      end
      exp_strobe = (pops != 0);
      rst_edge   = 0;
      last_acc   = rdy;
      mcount     = mcount + pushes - pops;
    end
  end

  // Monitor: compares every update against the scoreboard head
  always @(negedge clk) begin
    entry_t e;
    if (mon_en) begin
      if (rst_edge) begin
        hold_taken = 1'b0;
        hold_pc    = '0;
      end
      if (!res_ready) saw_bp = 1;
      checkOutput("res_ready", 32'(res_ready), 32'(mcount <= DEPTH - 2));
      checkOutput("occupancy", 32'(occupancy), 32'(mcount));
      checkOutput("is_b_ope", 32'(is_b_ope), 32'(exp_strobe));
      if (is_b_ope) begin
        strobe_cnt++;
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("is_branch", 32'(is_branch), 32'(e.taken));
          checkOutput("w_pc", 32'(w_pc), 32'(e.pc));
          hold_taken = e.taken;
          hold_pc    = e.pc;
        end
      end else begin
        checkOutput("hold_branch", 32'(is_branch), 32'(hold_taken));
        checkOutput("hold_pc", 32'(w_pc), 32'(hold_pc));
      end
    end
  end

  // Present one cycle of inputs from a negedge and return at the next negedge
  task automatic applyStimulus(input bit v0, input bit t0, input logic [PC_W-1:0] p0,
                               input bit v1, input bit t1, input logic [PC_W-1:0] p1);
    res0_valid = v0; res0_taken = t0; res0_pc = p0;
    res1_valid = v1; res1_taken = t1; res1_pc = p1;
    @(posedge clk);
    @(negedge clk);
    res0_valid = 1'b0;
    res1_valid = 1'b0;
  endtask

  // Hold a resolution pair until the queue takes it, as execute would
  task automatic sendPair(input bit v0, input bit t0, input logic [PC_W-1:0] p0,
                          input bit v1, input bit t1, input logic [PC_W-1:0] p1);
    int guard = 0;
    applyStimulus(v0, t0, p0, v1, t1, p1);
    while (!last_acc && guard < 50) begin
      applyStimulus(v0, t0, p0, v1, t1, p1);
      guard++;
    end
    if (!last_acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((sb.size() != 0 || mcount != 0) && guard < 40) begin
      idle(1);
      guard++;
    end
    if (sb.size() != 0 || mcount != 0) checkOutput("drain_timeout", 32'd0, 32'd1);
    idle(1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  // Directed sequence
  initial begin
    int start_cnt;
    rst = 1'b1;
    res0_valid = 0; res0_taken = 0; res0_pc = '0;
    res1_valid = 0; res1_taken = 0; res1_pc = '0;
    repeat (2) @(negedge clk);
    mon_en = 1;
    checkOutput("rst_is_b_ope", 32'(is_b_ope), 32'd0);
    checkOutput("rst_w_pc", 32'(w_pc), 32'd0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_res_ready", 32'(res_ready), 32'd1);
    rst = 1'b0;

    $display("[TB] single push");
    applyStimulus(1, 1, 14'h0123, 0, 0, '0);
    checkOutput("single_occ", 32'(occupancy), 32'd1);
    checkOutput("single_no_bypass", 32'(is_b_ope), 32'd0);
    idle(1);
    checkOutput("single_strobe", 32'(is_b_ope), 32'd1);
    checkOutput("single_branch", 32'(is_branch), 32'd1);
    checkOutput("single_pc", 32'(w_pc), 32'h0123);
    idle(1);
    checkOutput("single_done", 32'(is_b_ope), 32'd0);
    checkOutput("single_occ0", 32'(occupancy), 32'd0);
    checkOutput("single_hold", 32'(w_pc), 32'h0123);

    $display("[TB] dual push order");
    applyStimulus(1, 0, 14'h0010, 1, 1, 14'h0011);
    checkOutput("dual_occ", 32'(occupancy), 32'd2);
    idle(1);
    checkOutput("dual_pc0", 32'(w_pc), 32'h0010);
    checkOutput("dual_br0", 32'(is_branch), 32'd0);
    idle(1);
    checkOutput("dual_pc1", 32'(w_pc), 32'h0011);
    checkOutput("dual_br1", 32'(is_branch), 32'd1);
    idle(2);

    $display("[TB] res1-only push");
    applyStimulus(0, 0, '0, 1, 1, 14'h03FF);
    checkOutput("r1_occ", 32'(occupancy), 32'd1);
    idle(1);
    checkOutput("r1_strobe", 32'(is_b_ope), 32'd1);
    checkOutput("r1_pc", 32'(w_pc), 32'h03FF);
    idle(1);
    checkOutput("r1_single", 32'(is_b_ope), 32'd0);

    $display("[TB] backpressure with 100 random resolutions");
    saw_bp = 0;
    start_cnt = strobe_cnt;
    for (int i = 0; i < 50; i++) begin
      sendPair(1, 1'($urandom), PC_W'($urandom), 1, 1'($urandom), PC_W'($urandom));
    end
    waitDrain();
    checkOutput("bp_seen", 32'(saw_bp), 32'd1);
    checkOutput("bp_count", 32'(strobe_cnt - start_cnt), 32'd100);

    $display("[TB] wrap-around with mixed bursts");
    start_cnt = strobe_cnt;
    begin
      int k = 0;
      int mode = 0;
      while (k < 20) begin
        if (mode == 1 && k <= 18) begin
          sendPair(1, 1'(k), PC_W'(14'h200 + k), 1, 1'(k + 1), PC_W'(14'h200 + k + 1));
          k += 2;
        end else if (mode == 2) begin
          sendPair(0, 0, '0, 1, 1'(k), PC_W'(14'h200 + k));
          k += 1;
        end else begin
          sendPair(1, 1'(k), PC_W'(14'h200 + k), 0, 0, '0);
          k += 1;
        end
        mode = (mode + 1) % 3;
      end
    end
    waitDrain();
    checkOutput("wrap_count", 32'(strobe_cnt - start_cnt), 32'd20);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 4; i++) sendPair(1, 1, PC_W'(14'h3A0 + 2 * i), 1, 0, PC_W'(14'h3A1 + 2 * i));
    checkOutput("mid_occ5", 32'(occupancy), 32'd5);
    rst = 1'b1;
    applyStimulus(1, 1, 14'h1111, 1, 1, 14'h2222);
    rst = 1'b0;
    checkOutput("mid_strobe", 32'(is_b_ope), 32'd0);
    checkOutput("mid_occ", 32'(occupancy), 32'd0);
    checkOutput("mid_ready", 32'(res_ready), 32'd1);
    start_cnt = strobe_cnt;
    idle(10);
    checkOutput("mid_no_stale", 32'(strobe_cnt - start_cnt), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
